// File: rtl/seq_alu.sv
// Sequential ALU with a valid/ready handshake on both sides. Single-cycle ops
// complete in one cycle; MUL is an iterative shift-add taking WIDTH cycles.
module seq_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Opin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1110;

  localparam logic [SHAMT_W-1:0] LAST = SHAMT_W'(WIDTH - 1);

  logic [1:0]         state;
  logic [WIDTH-1:0]   mcand, mplier, acc, acc_nxt;
  logic [SHAMT_W-1:0] cnt;
  logic               accept;

  logic [WIDTH:0]     sum, dif;
  logic               ovf_add, ovf_sub;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v, alu_ill;

  assign out_valid = (state == DONE);
  assign in_ready  = !reset && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  // zero always tracks the registered result, so it can never lag a stale value
  assign zero      = (result == '0);

  assign sum     = {1'b0, A} + {1'b0, B};
  assign dif     = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
  assign ovf_add = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
  assign ovf_sub = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
  assign shamt   = B[SHAMT_W-1:0];
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (Opin)
      OP_ADD:  begin alu_res = sum[WIDTH-1:0]; alu_c = sum[WIDTH]; alu_v = ovf_add; end
      OP_SUB:  begin alu_res = dif[WIDTH-1:0]; alu_c = dif[WIDTH]; alu_v = ovf_sub; end
      // signed less-than uses the sign of A-B corrected for overflow
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, dif[WIDTH-1] ^ ovf_sub};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, ~dif[WIDTH]};
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_NOR:  alu_res = ~(A | B);
      OP_XOR:  alu_res = A ^ B;
      OP_SLL:  alu_res = A << shamt;
      OP_SRL:  alu_res = A >> shamt;
      OP_SRA:  alu_res = WIDTH'($signed(A) >>> shamt);
      OP_MUL:  ;
      default: alu_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
    end else begin
      case (state)
        BUSY: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + SHAMT_W'(1);
          if (cnt == LAST) begin
            state    <= DONE;
            result   <= acc_nxt;
            carry    <= 1'b0;
            overflow <= 1'b0;
            illegal  <= 1'b0;
            cnt      <= '0;
          end
        end
        default: begin
          if (accept) begin
            if (Opin == OP_MUL) begin
              state  <= BUSY;
              mcand  <= A;
              mplier <= B;
              acc    <= '0;
              cnt    <= '0;
            end else begin
              state    <= DONE;
              result   <= alu_res;
              carry    <= alu_c;
              overflow <= alu_v;
              illegal  <= alu_ill;
            end
          end else if (out_valid && out_ready) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed corner cases, back-to-back flow,
// reset during MUL and randomized ops against an arithmetic reference model.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] A, B, result;
  logic [3:0]  Opin;
  logic        zero, carry, overflow, illegal;
  int          n_cmp = 0;
  int          n_err = 0;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  seq_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Opin(Opin), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry), .overflow(overflow),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic c, output logic v, output logic il);
    longint sa, sb, s;
    logic [4:0] sh;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = b[4:0];
    r = '0; c = 1'b0; v = 1'b0; il = 1'b0;
    case (op)
      4'd0:  begin r = a + b; p = {32'b0, a} + {32'b0, b}; c = p[32];
                   s = sa + sb; v = (s > SMAX) || (s < SMIN); end
      4'd2:  begin r = a - b; c = (a >= b); s = sa - sb; v = (s > SMAX) || (s < SMIN); end
      4'd10: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd11: r = (a < b) ? 32'd1 : 32'd0;
      4'd4:  r = a & b;
      4'd5:  r = a | b;
      4'd7:  r = ~(a | b);
      4'd6:  r = a ^ b;
      4'd8:  r = a << sh;
      4'd9:  r = a >> sh;
      4'd12: r = 32'($signed(a) >>> sh);
      4'd14: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
      default: il = 1'b1;
    endcase
  endtask

  // One isolated operation: accept, measure latency, check, hold, then consume.
  task automatic op_run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic c, v, il;
    int lat, h;
    ref_alu(op, a, b, r, c, v, il);
    @(negedge clk);
    chk("idle_ready", in_ready, 1);
    in_valid = 1; A = a; B = b; Opin = op; out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0; A = $urandom; B = $urandom; Opin = 4'($urandom);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      chk("busy_ready", in_ready, 0);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, (op == 4'd14) ? 33 : 1);
    chk("result", result, r);
    chk("zero", zero, (r == 0));
    chk("carry", carry, c);
    chk("overflow", overflow, v);
    chk("illegal", illegal, il);
    h = $urandom_range(0, 2);
    repeat (h) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_result", result, r);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic b2b();
    logic [31:0] er[10];
    logic [3:0] op;
    logic [31:0] a, b, r;
    logic c, v, il;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("b2b_valid", out_valid, 1);
        chk("b2b_result", result, er[i-1]);
      end
      if (i < 10) begin
        chk("b2b_ready", in_ready, 1);
        case ($urandom_range(0, 2))
          0: op = 4'd4;
          1: op = 4'd5;
          default: op = 4'd6;
        endcase
        a = $urandom; b = $urandom;
        ref_alu(op, a, b, r, c, v, il);
        er[i] = r;
        in_valid = 1; out_ready = 1; A = a; B = b; Opin = op;
      end else begin
        in_valid = 0; out_ready = 0;
      end
    end
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_ready", in_ready, 0);
      chk("stall_result", result, er[9]);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic reset_mid_mul();
    @(negedge clk);
    in_valid = 1; A = 32'h1234_5678; B = 32'h9abc_def1; Opin = 4'd14;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (10) @(negedge clk);
    reset = 1; #1;
    chk("rst_ready_low", in_ready, 0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 1);
    repeat (35) begin
      @(negedge clk);
      chk("mul_discarded", out_valid, 0);
    end
    op_run(4'd0, 32'd2, 32'd3);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [3:0] op;
    reset = 1; in_valid = 0; out_ready = 0; A = '0; B = '0; Opin = '0;
    repeat (2) @(negedge clk);
    chk("reset_ready", in_ready, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_zero", zero, 1);
    chk("reset_flags", {carry, overflow, illegal}, 0);
    reset = 0; #1;
    chk("post_reset_ready", in_ready, 1);

    op_run(4'd0,  32'hFFFF_FFFF, 32'h1);
    op_run(4'd2,  32'h8000_0000, 32'h1);
    op_run(4'd10, 32'h8000_0000, 32'h1);
    op_run(4'd11, 32'h8000_0000, 32'h1);
    op_run(4'd14, 32'h0001_0003, 32'h5);
    op_run(4'd12, 32'h8000_0000, 32'h24);
    op_run(4'd15, 32'hDEAD_BEEF, 32'h1);
    op_run(4'd0,  32'h7FFF_FFFF, 32'h1);
    op_run(4'd2,  32'h0,         32'h1);
    op_run(4'd10, 32'h7FFF_FFFF, 32'h8000_0000);
    op_run(4'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    b2b();
    reset_mid_mul();

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom);
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'h8000_0000;
        1: b = 32'hFFFF_FFFF;
        2: b = a;
        default: ;
      endcase
      op_run(op, a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal values 8..64.
REQ-002 Parameter SHAMT_W, default 5, shift-amount bits taken from B[SHAMT_W-1:0]; SHALL equal clog2(WIDTH).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand/opcode presented.
REQ-006 in_ready  output  1  block accepts a new operation this cycle.
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B / shift amount.
REQ-009 Opin  input  4  opcode.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 result  output  WIDTH  operation result.
REQ-013 zero  output  1  result == 0.
REQ-014 carry  output  1  carry-out (ADD), no-borrow (SUB); 0 for other ops.
REQ-015 overflow  output  1  signed overflow (ADD/SUB); 0 for other ops.
REQ-016 illegal  output  1  opcode not in REQ-018 table.

Function
REQ-017 Accept = in_valid & in_ready; A, B and Opin SHALL be registered on accept; later input changes have no effect on the accepted operation.
REQ-018 Opcodes: 0000 ADD, 0010 SUB, 1010 SLT (signed), 1011 SLTU, 0100 AND, 0101 OR, 0111 NOR, 0110 XOR, 1000 SLL, 1001 SRL, 1100 SRA, 1110 MUL (low WIDTH bits of unsigned product).
REQ-019 SLT/SLTU result: 1 in bit 0, zeros elsewhere, when A < B, else all zeros; SLT SHALL use the overflow-corrected sign of A-B.
REQ-020 Shifts use B[SHAMT_W-1:0] only; SRA replicates A[WIDTH-1].
REQ-021 ADD/SUB arithmetic: WIDTH+1-bit internal sum; result wraps modulo 2^WIDTH; carry = bit WIDTH.
REQ-022 Illegal opcode: result = 0, zero = 1, illegal = 1, carry = overflow = 0, same latency as single-cycle ops.
REQ-023 FSM states: IDLE, BUSY, DONE.
REQ-024 IDLE: in_ready = 1; on accept of non-MUL op -> DONE with result registered (latency 1: out_valid high the cycle after accept); on accept of MUL -> BUSY.
REQ-025 BUSY: iterative shift-add, one multiplier bit per cycle, iteration counter 0..WIDTH-1; in_ready = 0; after WIDTH cycles -> DONE (out_valid asserted WIDTH+1 cycles after accept).
REQ-026 DONE: out_valid = 1; result and flags SHALL be held stable until out_ready = 1.
REQ-027 DONE with out_ready = 1: in_ready = 1 in the same cycle; simultaneous accept starts the next op (back-to-back, one result per cycle for non-MUL); with out_ready = 1 and no accept -> IDLE.
REQ-028 DONE with out_ready = 0: in_ready = 0; inputs ignored.
REQ-029 out_valid SHALL be 0 in IDLE and BUSY; flags are don't-care when out_valid = 0 but SHALL not change while out_valid = 1.
REQ-030 zero SHALL be computed from the final registered result, never from a previous result.

Reset
REQ-031 reset = 1 at a clock edge: state -> IDLE, out_valid = 0, result = 0, zero = 1, carry = overflow = illegal = 0, iteration counter = 0.
REQ-032 reset has priority over accept, iteration and out_ready in the same cycle; an in-flight MUL or a held result SHALL be discarded.
REQ-033 in_ready SHALL be 0 during reset and 1 in the first cycle after reset deasserts.

Verification
REQ-034 WIDTH=32, ADD A=0xFFFFFFFF B=1, out_ready=1 -> next cycle out_valid=1, result=0, zero=1, carry=1, overflow=0.
REQ-035 SUB A=0x80000000 B=1 -> result=0x7FFFFFFF, overflow=1, carry=1; SLT A=0x80000000 B=1 -> result=1; SLTU same operands -> result=0.
REQ-036 MUL A=0x00010003 B=0x00000005 accepted at cycle T -> out_valid first high at T+33, result=0x0005000F; in_ready=0 for cycles T+1..T+32.
REQ-037 Back-to-back: ten AND/OR/XOR ops with in_valid=1, out_ready=1 every cycle -> ten results on ten consecutive cycles in order; then out_ready=0 for 3 cycles -> result held, in_ready=0.
REQ-038 SRA A=0x80000000 B=0x00000024 (shamt 4) -> 0xF8000000; opcode 1111 -> result=0, zero=1, illegal=1.
REQ-039 reset asserted at T+10 of a MUL -> following cycle out_valid=0, in_ready=1, result=0; subsequent ADD 2+3 -> result=5.
